mux_n_to1_reg: RTL and testbench
================================

MUX_N_TO1_REG -- requirements
Module: mux_n_to1_reg

Interface
REQ-001 Parameter WIDTH, default 16: data bits per channel (SHALL be 1 or more).
REQ-002 Parameter N, default 4: number of input channels (SHALL be 2 or more); SELW = $clog2(N).
REQ-003 Parameter MODE, default 0: 0 = fixed select from sel, 1 = round-robin among valid inputs.
REQ-004 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready (combinational).
REQ-009 sel  input  SELW  selected channel in MODE 0; ignored in MODE 1.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_chan  output  SELW  index of the channel that supplied out_data.
REQ-012 out_valid  output  1  out_data holds an untaken word.
REQ-013 out_ready  input  1  downstream accepts the word this cycle.
REQ-014 xfer_count  output  16  count of accepted input transfers.

Function
REQ-015 load_en = !out_valid || out_ready; the single output stage SHALL accept a new word when load_en is high.
REQ-016 MODE 0: grant = sel; if sel >= N, no channel SHALL be granted and all in_ready SHALL be 0.
REQ-017 MODE 1: grant = first i with in_valid[i] high, scanning from ptr upward with wrap from N-1 to 0; no grant if all in_valid are low.
REQ-018 in_ready[i] = load_en && (i == grant); at most one in_ready bit SHALL be high in any cycle.
REQ-019 MODE 0: in_ready SHALL NOT depend on in_valid.
REQ-020 A transfer occurs when in_valid[grant] && in_ready[grant].
REQ-021 On a transfer, the next edge SHALL load out_data = that channel's data, out_chan = grant, out_valid = 1; latency is 1 cycle.
REQ-022 With no transfer and out_ready high, out_valid SHALL clear; out_data and out_chan SHALL hold.
REQ-023 While out_valid && !out_ready, out_data, out_chan and out_valid SHALL be held stable and all in_ready SHALL be 0.
REQ-024 A simultaneous output take and new transfer in the same cycle SHALL load the new word with out_valid staying 1, giving 1 word/cycle throughput.
REQ-025 MODE 1: after a transfer from channel g, ptr SHALL become (g+1) mod N; otherwise ptr SHALL hold. In MODE 0, ptr SHALL stay 0.
REQ-026 xfer_count SHALL increment by 1 on each transfer and wrap from 0xFFFF to 0x0000.
REQ-027 Non-granted channels SHALL be unaffected and keep their data pending; no data SHALL be dropped or duplicated.

Reset
REQ-028 When rst_n is low, the following SHALL clear immediately, independent of clk: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0, xfer_count = 0.
REQ-029 While rst_n is low, in_ready SHALL be 1 only at the current grant (load_en = 1), but no register SHALL update until rst_n is high.
REQ-030 Reset asserted mid-operation SHALL discard any held output word, and out_valid SHALL drop in the same cycle.

Verification
REQ-031 MODE 0, N=4, WIDTH=16, out_ready=1, sel=2, in_valid=4'b0100, ch2=0xBEEF -> next edge: out_data=0xBEEF, out_chan=2, out_valid=1, xfer_count=1.
REQ-032 MODE 0, sel=2 with a word held, out_ready=0 for 3 cycles -> out_data stable, in_ready=0000; out_ready=1 in cycle 4 -> next word loads in the same cycle (back-to-back).
REQ-033 MODE 1, all 4 in_valid held high, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 MODE 1, ptr=3, in_valid=4'b0011 -> grant ch0 (wrap), ptr becomes 1; next cycle grant ch1.
REQ-035 N=3 MODE 0, sel=3 -> in_ready=000, no transfer, xfer_count unchanged.
REQ-036 Preload xfer_count to 0xFFFF via 65535 transfers, then 1 more -> 0x0000; assert rst_n low mid-stall -> out_valid=0 asynchronously.

Source files
------------

// File: rtl/mux_n_to1_reg.sv
// mux_n_to1_reg: N-to-1 channel multiplexer with a single registered output stage.
// Selection is either fixed from sel (MODE 0) or round-robin among valid
// channels (MODE 1). The output stage is a one-entry valid/ready buffer that
// sustains one word per cycle when downstream keeps out_ready high.
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   in_data    - N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready (combinational, at most one bit high)
//   sel        - fixed channel select (MODE 0 only)
//   out_data   - registered selected word
//   out_chan   - channel index that supplied out_data
//   out_valid  - out_data holds an untaken word
//   out_ready  - downstream accepts the word this cycle
//   xfer_count - wrapping count of accepted input transfers
module mux_n_to1_reg #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          xfer_count
);

  logic [WIDTH-1:0] r_data;
  logic [SELW-1:0]  r_chan;
  logic             r_valid;
  logic [SELW-1:0]  r_ptr;
  logic [15:0]      r_cnt;

  logic             w_load_en;
  logic [SELW-1:0]  w_grant;
  logic             w_grant_vld;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_xfer;
  logic [SELW-1:0]  w_ptr_next;

  assign w_load_en = !r_valid || out_ready;

  // Grant selection. MODE 0 never looks at in_valid so in_ready stays
  // independent of it; MODE 1 scans from r_ptr upward with wrap.
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    if (MODE == 0) begin
      if (int'(sel) < N) begin
        w_grant     = sel;
        w_grant_vld = 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!w_grant_vld && in_valid[(32'(r_ptr) + k) % N]) begin
          w_grant     = SELW'((32'(r_ptr) + k) % N);
          w_grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    in_ready   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_grant_vld && (SELW'(i) == w_grant)) begin
        w_sel_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_load_en;
      end
    end
  end

  assign w_xfer     = |(in_ready & in_valid);
  assign w_ptr_next = SELW'((32'(w_grant) + 1) % N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer) begin
        r_data  <= w_sel_data;
        r_chan  <= w_grant;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + 16'd1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (MODE != 0 && w_xfer) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign out_data   = r_data;
  assign out_chan   = r_chan;
  assign out_valid  = r_valid;
  assign xfer_count = r_cnt;

endmodule

// File: tb/tb_mux_n_to1_reg.sv
// Directed testbench for mux_n_to1_reg: fixed-select (N=4 and N=3) and
// round-robin (N=4) instances sharing one clock and reset.
module tb_mux_n_to1_reg;

  logic clk;
  logic rst_n;

  // MODE 0, N=4, WIDTH=16
  logic [63:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_chan;
  logic [15:0] a_out_data, a_xfer;
  logic        a_out_valid, a_out_ready;

  // MODE 1, N=4, WIDTH=16
  logic [63:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_chan;
  logic [15:0] b_out_data, b_xfer;
  logic        b_out_valid, b_out_ready;

  // MODE 0, N=3, WIDTH=16
  logic [47:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic [1:0]  c_sel, c_out_chan;
  logic [15:0] c_out_data, c_xfer;
  logic        c_out_valid, c_out_ready;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mux_n_to1_reg #(.WIDTH(16), .N(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .xfer_count(a_xfer));

  mux_n_to1_reg #(.WIDTH(16), .N(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .xfer_count(b_xfer));

  mux_n_to1_reg #(.WIDTH(16), .N(3), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
    .out_chan(c_out_chan), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .xfer_count(c_xfer));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_data   = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    a_in_valid  = 4'b0000;
    a_sel       = 2'd2;
    a_out_ready = 1'b1;
    b_in_data   = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    b_in_valid  = 4'b0000;
    b_sel       = 2'd0;
    b_out_ready = 1'b1;
    c_in_data   = {16'hC002, 16'hC001, 16'hC000};
    c_in_valid  = 3'b000;
    c_sel       = 2'd3;
    c_out_ready = 1'b1;

    step();
    step();
    // Reset state
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  32'(a_out_data),  32'd0);
    chk("rst_out_chan",  32'(a_out_chan),  32'd0);
    chk("rst_xfer",      32'(a_xfer),      32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'b0100);
    rst_n = 1'b1;

    // Single fixed-select transfer
    a_in_valid = 4'b0100;
    #1;
    chk("m0_ready_pre", 32'(a_in_ready), 32'b0100);
    step();
    chk("m0_data",  32'(a_out_data),  32'hBEEF);
    chk("m0_chan",  32'(a_out_chan),  32'd2);
    chk("m0_valid", 32'(a_out_valid), 32'd1);
    chk("m0_xfer",  32'(a_xfer),      32'd1);

    // Stall three cycles, then back-to-back load
    a_out_ready = 1'b0;
    a_in_data[47:32] = 16'hCAFE;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", 32'(a_in_ready), 32'b0000);
      step();
      chk("stall_data",  32'(a_out_data),  32'hBEEF);
      chk("stall_valid", 32'(a_out_valid), 32'd1);
      chk("stall_xfer",  32'(a_xfer),      32'd1);
    end
    a_out_ready = 1'b1;
    #1;
    chk("b2b_ready", 32'(a_in_ready), 32'b0100);
    step();
    chk("b2b_data",  32'(a_out_data),  32'hCAFE);
    chk("b2b_valid", 32'(a_out_valid), 32'd1);
    chk("b2b_xfer",  32'(a_xfer),      32'd2);

    // Drain with no new input: valid clears, data/chan hold
    a_in_valid = 4'b0000;
    #1;
    chk("m0_ready_novalid", 32'(a_in_ready), 32'b0100);
    step();
    chk("drain_valid", 32'(a_out_valid), 32'd0);
    chk("drain_data",  32'(a_out_data),  32'hCAFE);
    chk("drain_chan",  32'(a_out_chan),  32'd2);
    chk("drain_xfer",  32'(a_xfer),      32'd2);

    // Round-robin with all channels valid: 0,1,2,3,0
    b_in_valid = 4'b1111;
    step(); chk("rr_chan0", 32'(b_out_chan), 32'd0); chk("rr_data0", 32'(b_out_data), 32'h1000);
    step(); chk("rr_chan1", 32'(b_out_chan), 32'd1); chk("rr_data1", 32'(b_out_data), 32'h1001);
    step(); chk("rr_chan2", 32'(b_out_chan), 32'd2); chk("rr_data2", 32'(b_out_data), 32'h1002);
    step(); chk("rr_chan3", 32'(b_out_chan), 32'd3); chk("rr_data3", 32'(b_out_data), 32'h1003);
    step(); chk("rr_chan4", 32'(b_out_chan), 32'd0); chk("rr_data4", 32'(b_out_data), 32'h1000);

    // ptr is 1: only ch2 valid -> grant 2, ptr becomes 3
    b_in_valid = 4'b0100;
    #1;
    chk("rr_skip_ready", 32'(b_in_ready), 32'b0100);
    step();
    chk("rr_skip_chan", 32'(b_out_chan), 32'd2);

    // ptr is 3, ch0/ch1 valid -> wrap to ch0, then ch1
    b_in_valid = 4'b0011;
    #1;
    chk("rr_wrap_ready", 32'(b_in_ready), 32'b0001);
    step();
    chk("rr_wrap_chan", 32'(b_out_chan), 32'd0);
    #1;
    chk("rr_next_ready", 32'(b_in_ready), 32'b0010);
    step();
    chk("rr_next_chan", 32'(b_out_chan), 32'd1);
    chk("rr_xfer",      32'(b_xfer),     32'd8);

    // Round-robin stall blocks all readies
    b_out_ready = 1'b0;
    b_in_valid  = 4'b1111;
    #1;
    chk("rr_stall_ready", 32'(b_in_ready), 32'b0000);
    step();
    chk("rr_stall_chan", 32'(b_out_chan), 32'd1);
    chk("rr_stall_xfer", 32'(b_xfer),     32'd8);

    // N=3 with out-of-range select
    c_in_valid = 3'b111;
    #1;
    chk("n3_oor_ready", 32'(c_in_ready), 32'b000);
    step();
    chk("n3_oor_xfer",  32'(c_xfer),      32'd0);
    chk("n3_oor_valid", 32'(c_out_valid), 32'd0);
    c_sel = 2'd1;
    #1;
    chk("n3_ready", 32'(c_in_ready), 32'b010);
    step();
    chk("n3_data", 32'(c_out_data), 32'hC001);
    chk("n3_xfer", 32'(c_xfer),     32'd1);

    // Counter wrap: 2 + 65533 = 0xFFFF, then one more -> 0
    a_sel      = 2'd0;
    a_in_valid = 4'b0001;
    for (int i = 0; i < 65533; i++) step();
    chk("cnt_ffff", 32'(a_xfer), 32'hFFFF);
    step();
    chk("cnt_wrap",  32'(a_xfer),     32'h0000);
    chk("cnt_data",  32'(a_out_data), 32'h1111);

    // Asynchronous reset in the middle of a stall
    a_out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(a_out_valid), 32'd0);
    chk("async_rst_data",  32'(a_out_data),  32'd0);
    chk("async_rst_chan",  32'(b_out_chan),  32'd0);
    chk("async_rst_xfer",  32'(b_xfer),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
